// File: rtl/mips_rf_pkg.sv
// Shared defaults for the scoreboarded MIPS register file: geometry, port counts
// and the hard-wired zero register address.
package mips_rf_pkg;

    localparam int RF_DW        = 32;
    localparam int RF_DEPTH     = 32;
    localparam int RF_NR        = 2;
    localparam int RF_NW        = 2;
    localparam int RF_ZERO_ADDR = 0;

endpackage : mips_rf_pkg

// File: rtl/mips_regfile_sb_if.sv
// Read/write/allocate bundle of the scoreboarded register file. The pipeline
// side is the master; the register file is the slave.
interface mips_regfile_sb_if
    import mips_rf_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = $clog2(RF_DEPTH),
    parameter int NR = RF_NR,
    parameter int NW = RF_NW
) ();

    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    rd_busy;
    logic [NW-1:0]    wr_en;
    logic [NW*AW-1:0] wr_addr;
    logic [NW*DW-1:0] wr_data;
    logic             alloc_en;
    logic [AW-1:0]    alloc_addr;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        input  rd_data, rd_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data, alloc_en, alloc_addr,
        output rd_data, rd_busy
    );

endinterface : mips_regfile_sb_if

// File: rtl/mips_rf_wr_merge.sv
// Folds the write ports into one enable/data pair per register. The highest port
// index wins a collision, and writes aimed at the zero register are dropped.
module mips_rf_wr_merge
    import mips_rf_pkg::*;
#(
    parameter int DW    = RF_DW,
    parameter int DEPTH = RF_DEPTH,
    parameter int AW    = $clog2(DEPTH),
    parameter int NW    = RF_NW
) (
    input  logic [NW-1:0]              wr_en_i,
    input  logic [NW*AW-1:0]           wr_addr_i,
    input  logic [NW*DW-1:0]           wr_data_i,
    output logic [DEPTH-1:0]           hit_o,
    output logic [DEPTH-1:0][DW-1:0]   data_o
);

    always_comb begin
        // NOTE: every output gets a default before the conditional updates below,
        // otherwise the unassigned paths would infer latches.
        hit_o  = '0;
        data_o = '0;
        // Ascending order lets a later (higher) port overwrite an earlier one.
        for (int p = 0; p < NW; p++) begin
            if (wr_en_i[p] && (wr_addr_i[p*AW +: AW] != AW'(RF_ZERO_ADDR))) begin
                hit_o[wr_addr_i[p*AW +: AW]]  = 1'b1;
                data_o[wr_addr_i[p*AW +: AW]] = wr_data_i[p*DW +: DW];
            end
        end
    end

endmodule : mips_rf_wr_merge

// File: rtl/mips_regfile_sb.sv
// Multi-ported register file with a per-register pending (scoreboard) bit.
// Reads are registered; BYPASS selects whether same-cycle updates are visible.
module mips_regfile_sb
    import mips_rf_pkg::*;
#(
    parameter int DW     = RF_DW,
    parameter int DEPTH  = RF_DEPTH,
    parameter int AW     = $clog2(DEPTH),
    parameter int NR     = RF_NR,
    parameter int NW     = RF_NW,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    mips_regfile_sb_if.slave  bus
);

    logic [DW-1:0]            regs_q [DEPTH];
    logic [DW-1:0]            regs_d [DEPTH];
    logic [DEPTH-1:0]         pend_q;
    logic [DEPTH-1:0]         pend_d;

    logic [DEPTH-1:0]         wr_hit;
    logic [DEPTH-1:0][DW-1:0] wr_val;
    logic                     alloc_hit;

    logic [NR-1:0][DW-1:0]    rd_data_d;
    logic [NR-1:0][DW-1:0]    rd_data_q;
    logic [NR-1:0]            rd_busy_d;
    logic [NR-1:0]            rd_busy_q;

    mips_rf_wr_merge #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW),
        .NW    (NW)
    ) u_wr_merge (
        .wr_en_i   (bus.wr_en),
        .wr_addr_i (bus.wr_addr),
        .wr_data_i (bus.wr_data),
        .hit_o     (wr_hit),
        .data_o    (wr_val)
    );

    assign alloc_hit = bus.alloc_en && (bus.alloc_addr != AW'(RF_ZERO_ADDR));

    always_comb begin
        regs_d = regs_q;
        pend_d = pend_q;
        for (int a = 0; a < DEPTH; a++) begin
            if (wr_hit[a]) begin
                regs_d[a] = wr_val[a];
                pend_d[a] = 1'b0;
            end
        end
        // Applied after the writeback clear: a new producer keeps the register busy.
        if (alloc_hit) begin
            pend_d[bus.alloc_addr] = 1'b1;
        end
    end

    for (genvar i = 0; i < NR; i++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = bus.rd_addr[i*AW +: AW];

        if (BYPASS != 0) begin : g_bypass
            assign rd_data_d[i] = regs_d[addr];
            assign rd_busy_d[i] = pend_d[addr];
        end else begin : g_no_bypass
            assign rd_data_d[i] = regs_q[addr];
            assign rd_busy_d[i] = pend_q[addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the storage array is reset explicitly because software relies
            // on every register reading zero after reset; this rules out a plain RAM.
            for (int a = 0; a < DEPTH; a++) begin
                regs_q[a] <= '0;
            end
            pend_q    <= '0;
            rd_data_q <= '0;
            rd_busy_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values; blocking
            // assignments here would chain updates through one edge.
            regs_q    <= regs_d;
            pend_q    <= pend_d;
            rd_data_q <= rd_data_d;
            rd_busy_q <= rd_busy_d;
        end
    end

    assign bus.rd_data = rd_data_q;
    assign bus.rd_busy = rd_busy_q;

endmodule : mips_regfile_sb

// File: tb/tb_mips_regfile_sb.sv
// Directed vectors run against a bypassing and a non-bypassing instance side by side.
module tb_mips_regfile_sb;

    localparam int DW    = 32;
    localparam int DEPTH = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int NW    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mips_regfile_sb_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) bus_byp ();
    mips_regfile_sb_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) bus_old ();

    mips_regfile_sb #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW), .NR(NR), .NW(NW), .BYPASS(1)
    ) dut_byp (
        .clk (clk),
        .rst (rst),
        .bus (bus_byp)
    );

    mips_regfile_sb #(
        .DW(DW), .DEPTH(DEPTH), .AW(AW), .NR(NR), .NW(NW), .BYPASS(0)
    ) dut_old (
        .clk (clk),
        .rst (rst),
        .bus (bus_old)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                         input logic [NW-1:0] we,
                         input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                         input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                         input logic ae, input logic [AW-1:0] aa);
        bus_byp.rd_addr    = {ra1, ra0};
        bus_byp.wr_en      = we;
        bus_byp.wr_addr    = {wa1, wa0};
        bus_byp.wr_data    = {wd1, wd0};
        bus_byp.alloc_en   = ae;
        bus_byp.alloc_addr = aa;
        bus_old.rd_addr    = {ra1, ra0};
        bus_old.wr_en      = we;
        bus_old.wr_addr    = {wa1, wa0};
        bus_old.wr_data    = {wd1, wd0};
        bus_old.alloc_en   = ae;
        bus_old.alloc_addr = aa;
    endtask

    task automatic read_only(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
        drive(ra0, ra1, '0, '0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_port(input string tag, input int p,
                               input logic [DW-1:0] d_byp, input logic b_byp,
                               input logic [DW-1:0] d_old, input logic b_old);
        check({tag, "/byp_data"}, bus_byp.rd_data[p*DW +: DW], d_byp);
        check({tag, "/byp_busy"}, 32'(bus_byp.rd_busy[p]), 32'(b_byp));
        check({tag, "/old_data"}, bus_old.rd_data[p*DW +: DW], d_old);
        check({tag, "/old_busy"}, 32'(bus_old.rd_busy[p]), 32'(b_old));
    endtask

    initial begin
        rst = 1'b1;
        read_only(5'd0, 5'd0);
        step();
        expect_port("reset_p0", 0, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_port("reset_p1", 1, 32'h0, 1'b0, 32'h0, 1'b0);

        rst = 1'b0;
        read_only(5'd5, 5'd31);
        step();
        expect_port("post_rst_r5", 0, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_port("post_rst_r31", 1, 32'h0, 1'b0, 32'h0, 1'b0);

        drive(5'd3, 5'd0, 2'b01, 5'd3, 5'd0, 32'hDEAD_BEEF, 32'h0, 1'b0, 5'd0);
        step();
        expect_port("wr3_same_cycle", 0, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
        read_only(5'd3, 5'd3);
        step();
        expect_port("wr3_next_p0", 0, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0);
        expect_port("wr3_next_p1", 1, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF, 1'b0);

        drive(5'd7, 5'd0, 2'b11, 5'd7, 5'd7, 32'h1, 32'h2, 1'b0, 5'd0);
        step();
        expect_port("wr7_collide", 0, 32'h2, 1'b0, 32'h0, 1'b0);
        read_only(5'd7, 5'd0);
        step();
        expect_port("wr7_after", 0, 32'h2, 1'b0, 32'h2, 1'b0);

        drive(5'd0, 5'd0, 2'b10, 5'd0, 5'd0, 32'h0, 32'hFFFF_FFFF, 1'b1, 5'd0);
        step();
        expect_port("r0_wr_alloc", 0, 32'h0, 1'b0, 32'h0, 1'b0);
        read_only(5'd0, 5'd0);
        step();
        expect_port("r0_after", 0, 32'h0, 1'b0, 32'h0, 1'b0);

        drive(5'd9, 5'd0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd9);
        step();
        expect_port("alloc9_same", 0, 32'h0, 1'b1, 32'h0, 1'b0);
        read_only(5'd9, 5'd0);
        step();
        expect_port("alloc9_next", 0, 32'h0, 1'b1, 32'h0, 1'b1);

        drive(5'd9, 5'd0, 2'b01, 5'd9, 5'd0, 32'h55, 32'h0, 1'b0, 5'd0);
        step();
        expect_port("wb9_same", 0, 32'h55, 1'b0, 32'h0, 1'b1);
        read_only(5'd9, 5'd0);
        step();
        expect_port("wb9_next", 0, 32'h55, 1'b0, 32'h55, 1'b0);

        drive(5'd9, 5'd0, 2'b01, 5'd9, 5'd0, 32'h66, 32'h0, 1'b1, 5'd9);
        step();
        expect_port("alloc_wb9_same", 0, 32'h66, 1'b1, 32'h55, 1'b0);
        read_only(5'd9, 5'd7);
        step();
        expect_port("alloc_wb9_next", 0, 32'h66, 1'b1, 32'h66, 1'b1);
        expect_port("r7_port1", 1, 32'h2, 1'b0, 32'h2, 1'b0);

        drive(5'd9, 5'd0, 2'b10, 5'd0, 5'd9, 32'h0, 32'h77, 1'b0, 5'd0);
        step();
        expect_port("wb9_port1", 0, 32'h77, 1'b0, 32'h66, 1'b1);

        rst = 1'b1;
        drive(5'd4, 5'd0, 2'b01, 5'd4, 5'd0, 32'h12, 32'h0, 1'b1, 5'd4);
        step();
        expect_port("rst_vs_wr4", 0, 32'h0, 1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        read_only(5'd4, 5'd9);
        step();
        expect_port("after_rst_r4", 0, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_port("after_rst_r9", 1, 32'h0, 1'b0, 32'h0, 1'b0);
        read_only(5'd3, 5'd7);
        step();
        expect_port("after_rst_r3", 0, 32'h0, 1'b0, 32'h0, 1'b0);
        expect_port("after_rst_r7", 1, 32'h0, 1'b0, 32'h0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mips_regfile_sb

// File: doc/mips_regfile_sb.md
MIPS_REGFILE_SB -- requirements
Module: mips_regfile_sb

Interface
REQ-001 Parameter DW, default 32: data width per register.
REQ-002 Parameter DEPTH, default 32: register count, power of two, >= 2.
REQ-003 Parameter AW, default $clog2(DEPTH): address width.
REQ-004 Parameter NR, default 2: read port count, 1..4.
REQ-005 Parameter NW, default 2: write port count, 1..2.
REQ-006 Parameter BYPASS, default 1: 1 forwards same-cycle writes to reads; 0 returns pre-write contents.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 rd_addr  input  NR*AW  read addresses; port i at bits [i*AW +: AW].
REQ-010 rd_data  output  NR*DW  registered read data, port i at [i*DW +: DW].
REQ-011 rd_busy  output  NR  registered scoreboard pending bit for each read address.
REQ-012 wr_en  input  NW  per-port write enable.
REQ-013 wr_addr  input  NW*AW  write addresses.
REQ-014 wr_data  input  NW*DW  write data.
REQ-015 alloc_en  input  1  marks alloc_addr as awaiting a writeback.
REQ-016 alloc_addr  input  AW  destination register being allocated.

Function
REQ-017 Register 0 SHALL read as zero; writes and allocs to address 0 are ignored; its pending bit is never set.
REQ-018 Read latency SHALL be one cycle: rd_data/rd_busy sampled at edge N reflect rd_addr presented in cycle N.
REQ-019 Write to address A with wr_en high SHALL update A at the rising edge of that cycle and clear pending[A].
REQ-020 Two write ports to the same nonzero address in one cycle: higher port index wins; lower port discarded.
REQ-021 BYPASS=1: read of an address being written in the same cycle SHALL return the winning new data; BYPASS=0: returns old contents.
REQ-022 alloc_en to nonzero A SHALL set pending[A] at the edge.
REQ-023 Alloc and write to the same address in one cycle: pending[A] SHALL remain set (newer producer); data is still written.
REQ-024 rd_busy[i] SHALL equal pending[rd_addr_i] after the same-cycle alloc/write updates when BYPASS=1, before them when BYPASS=0.
REQ-025 Out-of-range addresses cannot occur (DEPTH power of two); no wrap logic required.
REQ-026 No file I/O or simulation-only constructs in synthesizable RTL.

Reset
REQ-027 rst high at an edge SHALL zero all registers, all pending bits, rd_data and rd_busy.
REQ-028 rst SHALL dominate wr_en and alloc_en in the same cycle; those requests are discarded.
REQ-029 First read after rst deasserts SHALL return zero data, busy 0.

Structure
REQ-030 Package mips_rf_pkg SHALL hold default DW/DEPTH/NR/NW constants and the zero-register address constant.
REQ-031 One sub-module mips_rf_wr_merge SHALL resolve NW write ports into per-address enable/data with port priority and address-0 masking.
REQ-032 Storage and pending bits SHALL be flat arrays in the top; read muxes generated per port.

Verification
REQ-033 rst 1 cycle, then read addr 5 and 31 -> rd_data 0, rd_busy 0 next cycle.
REQ-034 wr port0 addr 3 = 0xDEADBEEF, same-cycle read addr 3 -> BYPASS=1: 0xDEADBEEF; BYPASS=0: 0, then 0xDEADBEEF next read.
REQ-035 wr port0 addr 7 = 0x1, port1 addr 7 = 0x2 same cycle -> read addr 7 returns 0x2.
REQ-036 wr addr 0 = 0xFFFFFFFF, alloc addr 0 -> read addr 0 returns 0, busy 0.
REQ-037 alloc addr 9; next cycle read 9 -> busy 1; write 9 = 0x55 -> busy 0, data 0x55; alloc+write 9 same cycle -> busy stays 1.
REQ-038 wr addr 4 = 0x12 and rst asserted same cycle -> read addr 4 returns 0.
